// File: rtl/xheep_jtag_master.sv
// JTAG initiator driving a TAP from a command/response stream; TCK = clk_i / (2*CLK_DIV).
// Latency accept->rsp_valid is P*2*CLK_DIV+1 cycles; response holds until rsp_ready_i, no new command meanwhile.
module xheep_jtag_master #(
    parameter int MAX_LEN = 64,
    parameter int LEN_W   = 7,
    parameter int CLK_DIV = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [1:0]         cmd_op_i,
    input  logic [LEN_W-1:0]   cmd_len_i,
    input  logic [MAX_LEN-1:0] cmd_data_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [MAX_LEN-1:0] rsp_data_o,
    output logic               busy_o,
    output logic               jtag_tck_o,
    output logic               jtag_tms_o,
    output logic               jtag_tdi_o,
    output logic               jtag_trst_no,
    input  logic               jtag_tdo_i
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [1:0] OP_RESET = 2'd0;
    localparam logic [1:0] OP_IR    = 2'd1;
    localparam logic [1:0] OP_DR    = 2'd2;
    localparam logic [1:0] OP_IDLE  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_TRST, S_HDR, S_RUN, S_SHIFT, S_TRL, S_RSP
    } state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [MAX_LEN-1:0] data_q, data_d;
    logic [MAX_LEN-1:0] rdata_q, rdata_d;
    logic               tck_q, tck_d;
    logic               tms_q, tms_d;
    logic               tdi_q, tdi_d;
    logic               trst_q, trst_d;

    logic               accept;
    logic               active;
    logic               phase_end;
    logic               tck_fall;
    logic [LEN_W-1:0]   len_clamp;
    logic [LEN_W-1:0]   hdr_last;
    logic [1:0]         op_n;
    logic [LEN_W-1:0]   len_n;
    logic [MAX_LEN-1:0] data_n;

    assign accept    = cmd_valid_i & cmd_ready_o;
    assign active    = (state_q == S_TRST) || (state_q == S_HDR) || (state_q == S_RUN) ||
                       (state_q == S_SHIFT) || (state_q == S_TRL);
    assign phase_end = active && (div_q == DIV_W'(CLK_DIV - 1));
    assign tck_fall  = phase_end && tck_q;
    assign len_clamp = (cmd_len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len_i;
    assign op_n      = accept ? cmd_op_i   : op_q;
    assign len_n     = accept ? len_clamp  : len_q;
    assign data_n    = accept ? cmd_data_i : data_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            op_q    <= OP_RESET;
            len_q   <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            tck_q   <= 1'b0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
            trst_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            len_q   <= len_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            tck_q   <= tck_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
            trst_q  <= trst_d;
        end
    end

    always_comb begin
        case (op_q)
            OP_RESET: hdr_last = LEN_W'(5);
            OP_IR:    hdr_last = LEN_W'(3);
            default:  hdr_last = LEN_W'(2);
        endcase
    end

    // Advances one TCK period per falling edge; cnt_q indexes the period within the state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d = '0;
                    case (cmd_op_i)
                        OP_RESET: state_d = S_TRST;
                        OP_IDLE:  state_d = (len_clamp == '0) ? S_RSP : S_RUN;
                        default:  state_d = (len_clamp == '0) ? S_RSP : S_HDR;
                    endcase
                end
            end
            S_TRST: begin
                if (tck_fall) begin
                    state_d = S_HDR;
                    cnt_d   = '0;
                end
            end
            S_HDR: begin
                if (tck_fall) begin
                    if (cnt_q == hdr_last) begin
                        state_d = (op_q == OP_RESET) ? S_RSP : S_SHIFT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
            end
            S_SHIFT: begin
                if (tck_fall) begin
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        state_d = S_TRL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
            end
            S_TRL: begin
                if (tck_fall) begin
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = S_RSP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
            end
            S_RUN: begin
                if (tck_fall) begin
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        state_d = S_RSP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
            end
            S_RSP: begin
                if (rsp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pin values for the upcoming period are chosen from the next state/count on accept or TCK fall.
    always_comb begin
        div_d   = (active && !phase_end) ? div_q + DIV_W'(1) : '0;
        tck_d   = phase_end ? !tck_q : tck_q;
        op_d    = op_n;
        len_d   = len_n;
        data_d  = data_n;
        rdata_d = rdata_q;
        tms_d   = tms_q;
        tdi_d   = tdi_q;
        trst_d  = trst_q;
        if (accept) rdata_d = '0;
        if (tck_fall && state_q == S_SHIFT) rdata_d[cnt_q[IDX_W-1:0]] = jtag_tdo_i;
        if (accept || tck_fall) begin
            tdi_d  = 1'b0;
            trst_d = 1'b1;
            case (state_d)
                S_TRST: begin
                    tms_d  = 1'b1;
                    trst_d = 1'b0;
                end
                S_HDR: begin
                    case (op_n)
                        OP_RESET: tms_d = (cnt_d < LEN_W'(5));
                        OP_IR:    tms_d = (cnt_d < LEN_W'(2));
                        default:  tms_d = (cnt_d < LEN_W'(1));
                    endcase
                end
                S_SHIFT: begin
                    tms_d = (cnt_d == len_n - LEN_W'(1));
                    tdi_d = data_n[cnt_d[IDX_W-1:0]];
                end
                S_TRL:   tms_d = (cnt_d == '0);
                S_RUN:   tms_d = 1'b0;
                default: tms_d = tms_q;
            endcase
        end
    end

    always_comb begin
        rsp_valid_o  = (state_q == S_RSP);
        cmd_ready_o  = (state_q == S_IDLE) && !rsp_valid_o;
        busy_o       = (state_q != S_IDLE);
        rsp_data_o   = rdata_q;
        jtag_tck_o   = tck_q;
        jtag_tms_o   = tms_q;
        jtag_tdi_o   = tdi_q;
        jtag_trst_no = trst_q;
    end

endmodule

// File: doc/xheep_jtag_master.md
Name: xheep_jtag_master

Overview:
- PL-side JTAG initiator that drives the debug TAP of x_heep_system (jtag_tck/tms/tdi/trst_n in, tdo out) from a simple command/response stream.
- Lets on-chip logic or a PS-attached register block reset the TAP, load IR, shift DR and idle-clock without an external probe.
- Sits beside x_heep_system in the FPGA top and replaces pad-level JTAG when selected.

Parameters:
- MAX_LEN, 64, maximum shift length in bits; cmd_data/rsp_data width.
- LEN_W, 7, width of cmd_len_i; must satisfy 2**LEN_W > MAX_LEN.
- CLK_DIV, 4, clk_i cycles per TCK half-period; must be >= 1. TCK = f(clk_i) / (2*CLK_DIV).

Ports:
- clk_i  in  1  system clock (only clock)
- rst_ni  in  1  synchronous active-low reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid & ready
- cmd_op_i  in  2  0=TAP_RESET, 1=SHIFT_IR, 2=SHIFT_DR, 3=RUN_IDLE
- cmd_len_i  in  LEN_W  shift bits (ops 1/2) or idle TCK count (op 3)
- cmd_data_i  in  MAX_LEN  TDI bits, bit 0 shifted first
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid & ready
- rsp_data_o  out  MAX_LEN  captured TDO bits, bit 0 first captured
- busy_o  out  1  high from command accept until response handshake
- jtag_tck_o  out  1  TCK to target
- jtag_tms_o  out  1  TMS to target
- jtag_tdi_o  out  1  TDI to target
- jtag_trst_no  out  1  TRST, active low
- jtag_tdo_i  in  1  TDO from target

Behaviour:
- Clock/reset: one clock, clk_i; reset rst_ni is synchronous and active-low. Reset applies at any time, including mid-operation, with no TCK glitch beyond tck forced to 0 on that edge.
- Reset values: tck 0, tms 1, tdi 0, trst_no 1, cmd_ready 1, rsp_valid 0, rsp_data 0, busy 0, FSM IDLE.
- FSM states: IDLE -> (TRST | HDR | RUN) -> SHIFT -> TRL -> RSP -> IDLE. Unused states are skipped per op.
- TCK period: a low phase of CLK_DIV cycles followed by a high phase of CLK_DIV cycles.
  - tms/tdi update only on the clk edge where tck goes 1->0, or at the first low phase after accept.
  - tdo is sampled on the clk edge that ends the high phase.
- cmd_ready_o = (state==IDLE) & !rsp_valid_o. The command is latched on accept; cmd_len is clamped to MAX_LEN.
- TAP_RESET:
  - 1 period with trst_no=0, tms=1.
  - then 5 periods tms=1, then 1 period tms=0, ending in Run-Test/Idle.
  - 7 periods total; rsp_data=0.
- SHIFT_IR:
  - header tms 1,1,0,0 (4 periods).
  - N shift periods with tdi=data[i]; tms=0 except the last shift, which has tms=1.
  - trailer tms 1,0 (2 periods).
  - N+6 periods total.
- SHIFT_DR: header tms 1,0,0 (3 periods); shift and trailer as for SHIFT_IR; N+5 periods total.
- RUN_IDLE: N periods with tms=0, tdi=0; rsp_data=0.
- Capture: TDO sampled in shift period i goes to rsp_data[i]; bits >= N are 0. tdi=0 outside shift periods.
- len=0 on any op except TAP_RESET: no TCK activity; rsp_valid asserts the cycle after accept, with rsp_data=0.
- Response: rsp_valid_o rises on the cycle after the final high phase ends (tck back to 0). It holds, with data stable, until rsp_ready_i. Return to IDLE takes 1 cycle.
- Latency, accept to rsp_valid: P*2*CLK_DIV + 1 cycles, where P = period count.
- Between commands: tck idles at 0 and tms holds its last value (0 after any completed op).

Test Plan:
- CLK_DIV=2, TAP_RESET: trst_no low for exactly 4 clk cycles, then 5 tck pulses with tms=1 and 1 with tms=0 -> rsp_valid at accept+29, rsp_data=0.
- TAP model with IDCODE 0x249511C3: TAP_RESET, then SHIFT_DR len=32 data=0 -> rsp_data[31:0]=0x249511C3, 37 tck pulses, tms high only on shift bit 31 and the first trailer period.
- SHIFT_IR len=5 data=0x11 into TAP model -> tdi sequence 1,0,0,0,1; model IR=0x11; rsp_data=0x01 (capture pattern); tms header 1,1,0,0 checked.
- Hold rsp_ready_i low for 20 cycles after a SHIFT_DR -> rsp_valid/rsp_data stable, cmd_ready_o=0, and a second cmd_valid is not accepted until the handshake.
- cmd_len=0 SHIFT_DR -> no tck edges, rsp at accept+1. cmd_len=100 with MAX_LEN=64 -> exactly 64 shift periods.
- rst_ni low for 1 cycle in the middle of a SHIFT_DR high phase -> next cycle tck=0, tms=1, busy=0, cmd_ready=1, no rsp_valid; a subsequent TAP_RESET completes normally.
